// File: rtl/pulse_burst_pkg.sv
// rtl/pulse_burst_pkg.sv - shared state encoding and default widths for pulse_burst_gen
package pulse_burst_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_CNT_W  = 26;
  localparam int DEF_NUM_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/pulse_burst_ch.sv
// rtl/pulse_burst_ch.sv - one burst channel: FSM, shadow registers and counters
module pulse_burst_ch
  import pulse_burst_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] half_period_i,
  input  logic [NUM_W-1:0] pulse_cnt_i,
  output logic             pwm_o,
  output logic             busy_o,
  output logic             done_o
);

  ch_state_e        state_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] phase_q;
  logic [NUM_W-1:0] rem_q;
  logic             pwm_q;
  logic             busy_q;
  logic             done_q;

  logic             phase_end_d;
  logic             last_low_d;
  logic             params_ok_d;

  // End-of-phase and end-of-burst detection; half_q is never zero while running,
  // so half_q-1 cannot underflow when it matters.
  always_comb begin
    phase_end_d = (phase_q == (half_q - CNT_W'(1)));
    last_low_d  = phase_end_d && !pwm_q && (rem_q == '0);
    params_ok_d = (half_period_i != '0) && (pulse_cnt_i != '0);
  end

  // Channel FSM with registered pwm/busy/done; rem counts falling edges still owed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            if (params_ok_d) begin
              half_q  <= half_period_i;
              rem_q   <= pulse_cnt_i;
              phase_q <= '0;
              pwm_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            phase_q <= '0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (last_low_d) begin
            phase_q <= '0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else if (phase_end_d) begin
            phase_q <= '0;
            pwm_q   <= !pwm_q;
            if (pwm_q) begin
              rem_q <= rem_q - NUM_W'(1);
            end
          end else begin
            phase_q <= phase_q + CNT_W'(1);
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          pwm_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pwm_o  = pwm_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - NUM_CH independent pulse-burst channels on flattened buses
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NUM_W  = DEF_NUM_W
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] half_period,
  input  logic [NUM_CH*NUM_W-1:0] pulse_cnt,
  output logic [NUM_CH-1:0]       pwm,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  // One channel instance per bit lane, each slicing its own field of the buses.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_burst_ch #(
      .CNT_W(CNT_W),
      .NUM_W(NUM_W)
    ) u_ch (
      .clk_i        (sys_clk),
      .rst_i        (sys_rst),
      .start_i      (start[i]),
      .abort_i      (abort[i]),
      .half_period_i(half_period[i*CNT_W +: CNT_W]),
      .pulse_cnt_i  (pulse_cnt[i*NUM_W +: NUM_W]),
      .pwm_o        (pwm[i]),
      .busy_o       (busy[i]),
      .done_o       (done[i])
    );
  end

endmodule
